// File: rtl/masked_xor_seq_pkg.sv
// Shared types and constants for the masked XOR sequencer.
package masked_xor_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RND = 3'd1,
    S_EXEC     = 3'd2,
    S_DONE     = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int FLUSH_CNT_W      = 4;

endpackage

// File: rtl/masked_xor_sequencer.sv
// Sequencer for an external two-share masked XOR core: operand/RNG intake,
// single-cycle evaluation window, result handout and share precharge.
module masked_xor_sequencer
  import masked_xor_seq_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a0,
  input  logic             in_a1,
  input  logic             in_b0,
  input  logic             in_b1,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [2:0]       rnd,
  output logic             core_input1_0,
  output logic             core_input1_1,
  output logic             core_input2_0,
  output logic             core_input2_1,
  output logic             core_r0,
  output logic             core_r1,
  output logic             core_r2,
  input  logic             core_xor_0,
  input  logic             core_xor_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_0,
  output logic             out_1,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             opnd_p0;      // {a0, a1, b0, b1}
  logic [2:0]             rnd_p0;       // {r2, r1, r0}
  logic [1:0]             res_p1;       // {xor_0, xor_1}
  logic [CNT_W-1:0]       op_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic                   exec;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (in_valid)           state_d = S_WAIT_RND;
      S_WAIT_RND: if (rnd_valid)          state_d = S_EXEC;
      S_EXEC:                             state_d = S_DONE;
      S_DONE:     if (out_ready)          state_d = S_FLUSH;
      S_FLUSH:    if (flush_cnt_q == '0)  state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Share registers are cleared on reset too, so a discarded operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_p0     <= '0;
      rnd_p0      <= '0;
      res_p1      <= '0;
      op_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE:     if (in_valid)  opnd_p0 <= {in_a0, in_a1, in_b0, in_b1};
        S_WAIT_RND: if (rnd_valid) rnd_p0  <= rnd;
        // --- stage boundary: core evaluation -> result register ---
        S_EXEC:     res_p1 <= {core_xor_0, core_xor_1};
        S_DONE: begin
          if (out_ready) begin
            op_cnt_q    <= op_cnt_q + CNT_W'(1);
            flush_cnt_q <= FLUSH_CNT_INIT;
            opnd_p0     <= '0;
            rnd_p0      <= '0;
            res_p1      <= '0;
          end
        end
        S_FLUSH: begin
          opnd_p0 <= '0;
          rnd_p0  <= '0;
          res_p1  <= '0;
          if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Shares reach the core only inside the evaluation window; elsewhere the lines idle at zero.
  assign exec      = (state_q == S_EXEC);
  assign in_ready  = (state_q == S_IDLE);
  assign rnd_ready = (state_q == S_WAIT_RND);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign op_count  = op_cnt_q;

  assign {core_input1_0, core_input1_1, core_input2_0, core_input2_1} = exec ? opnd_p0 : 4'b0;
  assign {core_r2, core_r1, core_r0} = exec ? rnd_p0 : 3'b0;
  assign {out_0, out_1} = out_valid ? res_p1 : 2'b0;

endmodule

// File: tb/tb_masked_xor_sequencer.sv
// Directed bench for masked_xor_sequencer with a behavioural two-share XOR core.
module tb_masked_xor_sequencer;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_a0, in_a1, in_b0, in_b1, rnd_valid, out_ready;
  logic [2:0] rnd;

  logic        in_ready_1, rnd_ready_1, out_valid_1, out0_1, out1_1, busy_1;
  logic [15:0] cnt_1;
  logic        ci10_1, ci11_1, ci20_1, ci21_1, cr0_1, cr1_1, cr2_1, cx0_1, cx1_1;
  logic        in_ready_2, rnd_ready_2, out_valid_2, out0_2, out1_2, busy_2;
  logic [1:0]  cnt_2;
  logic        ci10_2, ci11_2, ci20_2, ci21_2, cr0_2, cr1_2, cr2_2, cx0_2, cx1_2;

  always #5 clk = ~clk;

  // Behavioural masked core: each result share is refreshed with r0.
  assign cx0_1 = ci10_1 ^ ci20_1 ^ cr0_1;
  assign cx1_1 = ci11_1 ^ ci21_1 ^ cr0_1;
  assign cx0_2 = ci10_2 ^ ci20_2 ^ cr0_2;
  assign cx1_2 = ci11_2 ^ ci21_2 ^ cr0_2;

  masked_xor_sequencer dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_1), .rnd(rnd),
    .core_input1_0(ci10_1), .core_input1_1(ci11_1), .core_input2_0(ci20_1), .core_input2_1(ci21_1),
    .core_r0(cr0_1), .core_r1(cr1_1), .core_r2(cr2_1),
    .core_xor_0(cx0_1), .core_xor_1(cx1_1),
    .out_valid(out_valid_1), .out_ready(out_ready), .out_0(out0_1), .out_1(out1_1),
    .busy(busy_1), .op_count(cnt_1)
  );

  masked_xor_sequencer #(.CNT_W(2), .FLUSH_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_a0(in_a0), .in_a1(in_a1), .in_b0(in_b0), .in_b1(in_b1),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_2), .rnd(rnd),
    .core_input1_0(ci10_2), .core_input1_1(ci11_2), .core_input2_0(ci20_2), .core_input2_1(ci21_2),
    .core_r0(cr0_2), .core_r1(cr1_2), .core_r2(cr2_2),
    .core_xor_0(cx0_2), .core_xor_1(cx1_2),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_0(out0_2), .out_1(out1_2),
    .busy(busy_2), .op_count(cnt_2)
  );

  // sel picks which instance the checks observe.
  logic        sel;
  logic        m_in_ready, m_rnd_ready, m_out_valid, m_busy;
  logic [6:0]  m_core;
  logic [1:0]  m_out;
  logic [15:0] m_cnt;
  assign m_in_ready  = sel ? in_ready_2  : in_ready_1;
  assign m_rnd_ready = sel ? rnd_ready_2 : rnd_ready_1;
  assign m_out_valid = sel ? out_valid_2 : out_valid_1;
  assign m_busy      = sel ? busy_2      : busy_1;
  assign m_core = sel ? {ci10_2, ci11_2, ci20_2, ci21_2, cr2_2, cr1_2, cr0_2}
                      : {ci10_1, ci11_1, ci20_1, ci21_1, cr2_1, cr1_1, cr0_1};
  assign m_out  = sel ? {out0_2, out1_2} : {out0_1, out1_1};
  assign m_cnt  = sel ? {14'b0, cnt_2} : cnt_1;

  int rnd_hs = 0;
  always @(posedge clk) if (!rst && rnd_valid && m_rnd_ready) rnd_hs <= rnd_hs + 1;

  typedef struct {
    logic [3:0] sh;   // {a0, a1, b0, b1}
    logic [2:0] r;
    logic       recon;
  } vec_t;

  vec_t tbl[128];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] sh, input logic [2:0] r, input logic recon,
                        input int stall, input int bp, input bit early);
    logic [1:0]  exp_sh, held;
    logic [15:0] cnt_before;
    int          hs0, fc;
    exp_sh = {sh[3] ^ sh[1] ^ r[0], sh[2] ^ sh[0] ^ r[0]};
    check("idle_in_ready", m_in_ready, 1);
    {in_a0, in_a1, in_b0, in_b1} = sh;
    in_valid = 1'b1;
    if (early) begin
      rnd_valid = 1'b1;
      rnd = ~r;
      check("early_rnd_ready", m_rnd_ready, 0);
    end
    hs0 = rnd_hs;
    tick();
    rnd_valid = 1'b0;
    if (early) check("early_rnd_not_taken", rnd_hs, hs0);
    if (stall > 0) {in_a0, in_a1, in_b0, in_b1} = ~sh;
    else in_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("stall_rnd_ready", m_rnd_ready, 1);
      check("stall_in_ready", m_in_ready, 0);
      check("stall_core_zero", m_core, 0);
      check("stall_out_valid", m_out_valid, 0);
      tick();
    end
    in_valid  = 1'b0;
    rnd_valid = 1'b1;
    rnd       = r;
    tick();
    rnd_valid = 1'b0;
    rnd       = 3'b0;
    check("exec_core", m_core, {sh, r});
    check("exec_rnd_ready", m_rnd_ready, 0);
    check("exec_out_valid", m_out_valid, 0);
    out_ready = (bp == 0);
    tick();
    check("done_out_valid", m_out_valid, 1);
    check("done_shares", m_out, exp_sh);
    check("done_recon", m_out[1] ^ m_out[0], recon);
    check("done_core_zero", m_core, 0);
    held       = m_out;
    cnt_before = m_cnt;
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_out_valid", m_out_valid, 1);
      check("bp_hold", m_out, held);
      check("bp_in_ready", m_in_ready, 0);
      check("bp_count", m_cnt, cnt_before);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = sel ? ((exp_cnt + 1) % 4) : ((exp_cnt + 1) % 65536);
    check("op_count", m_cnt, exp_cnt);
    fc = 0;
    while (!m_in_ready && fc < 20) begin
      check("flush_zero", {m_out_valid, m_out, m_core}, 0);
      check("flush_busy", m_busy, 1);
      fc++;
      tick();
    end
    check("flush_cycles", fc, sel ? 3 : 1);
  endtask

  task automatic reset_mid(input bit at_done);
    in_valid = 1'b1;
    {in_a0, in_a1, in_b0, in_b1} = 4'b1011;
    tick();
    in_valid  = 1'b0;
    rnd_valid = 1'b1;
    rnd       = 3'b110;
    tick();
    rnd_valid = 1'b0;
    if (at_done) tick();
    check("pre_rst_state", m_out_valid, at_done);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", m_in_ready, 1);
    check("rst_busy", m_busy, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_zero", {m_out, m_core}, 0);
    check("rst_count", m_cnt, 0);
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hs_start;
    int seq[5];
    sel = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0; rnd = 3'b0;
    {in_a0, in_a1, in_b0, in_b1} = 4'b0;
    for (int i = 0; i < 128; i++) begin
      tbl[i].sh    = 4'(i >> 3);
      tbl[i].r     = 3'(i);
      tbl[i].recon = tbl[i].sh[3] ^ tbl[i].sh[2] ^ tbl[i].sh[1] ^ tbl[i].sh[0];
    end
    seq = '{1, 2, 3, 0, 1};

    tick(); tick();
    check("reset_out_valid", m_out_valid, 0);
    check("reset_rnd_ready", m_rnd_ready, 0);
    check("reset_core_zero", {m_out, m_core}, 0);
    check("reset_count", m_cnt, 0);
    rst = 1'b0;
    tick();
    check("reset_in_ready", m_in_ready, 1);
    check("reset_busy", m_busy, 0);

    // Basic op: A=1, B=0.
    run_op(4'b1011, 3'b101, 1'b1, 0, 0, 1'b0);
    // RNG stall with a changed operand offered meanwhile.
    run_op(4'b0110, 3'b011, 1'b0, 10, 0, 1'b0);
    // Output backpressure.
    run_op(4'b1100, 3'b111, 1'b0, 0, 5, 1'b0);
    // Operand and RNG offered together in IDLE.
    run_op(4'b0001, 3'b010, 1'b1, 0, 0, 1'b1);

    hs_start = rnd_hs;
    for (int i = 0; i < 128; i++) run_op(tbl[i].sh, tbl[i].r, tbl[i].recon, 0, 0, 1'b0);
    check("rnd_once_per_op", rnd_hs - hs_start, 128);

    reset_mid(1'b0);
    run_op(4'b1001, 3'b001, 1'b0, 0, 0, 1'b0);
    reset_mid(1'b1);

    // Narrow counter wrap and longer precharge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sel = 1'b1;
    exp_cnt = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      run_op(4'(i * 3), 3'(i + 2), ^(4'(i * 3)), 0, 0, 1'b0);
      check("wrap_seq", m_cnt, seq[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/masked_xor_sequencer.md
Name: masked_xor_sequencer

Overview:
Sequences the two-share masked XOR core: accepts shared operand pairs over valid/ready, fetches exactly one fresh 3-bit randomness word per operation, and presents operands to the core only during a single evaluation cycle. It registers the core result and hands it out over valid/ready. It then precharges all share-carrying registers to zero before the next operation. Sits between the operand producer/RNG and the combinational masked XOR core, which connects through the core_* ports.

Parameters:
CNT_W, 16, width of the completed-operation counter (wraps modulo 2^CNT_W)
FLUSH_CYCLES, 1, number of precharge cycles after each completed operation (legal range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  sequencer can accept an operand pair
in_a0, in_a1  in  1 each  shares of operand A
in_b0, in_b1  in  1 each  shares of operand B
rnd_valid  in  1  RNG word available
rnd_ready  out  1  sequencer consumes RNG word
rnd  in  3  fresh randomness {r2,r1,r0}
core_input1_0, core_input1_1, core_input2_0, core_input2_1  out  1 each  core operand shares
core_r0, core_r1, core_r2  out  1 each  core randomness
core_xor_0, core_xor_1  in  1 each  combinational core result shares
out_valid  out  1  result shares valid
out_ready  in  1  consumer accepts result
out_0, out_1  out  1 each  result shares
busy  out  1  high whenever state != IDLE
op_count  out  CNT_W  completed operations (handshake on output)

Behaviour:
- States: IDLE, WAIT_RND, EXEC, DONE, FLUSH.
- Reset (sync, checked every edge, overrides all events): state=IDLE; operand, randomness and output registers = 0; op_count=0; in_ready=1 after reset deasserts; all other outputs 0. An in-flight operation is discarded with no output and no count.
- IDLE: in_ready=1. On in_valid&in_ready, latch the four shares and go to WAIT_RND.
- WAIT_RND: rnd_ready=1, and only in this state. On rnd_valid, latch rnd and go to EXEC. With no rnd_valid, wait indefinitely.
- EXEC (exactly 1 cycle): core_* driven from the latched registers. At the end of the cycle, capture core_xor_0/1 into out_0/out_1 and go to DONE.
- core_* outputs = 0 in every state except EXEC.
- DONE: out_valid=1, out_0/out_1 stable. On out_ready: op_count+1 (wraps), go to FLUSH.
- FLUSH: zero operand, randomness and output registers. Hold for FLUSH_CYCLES cycles via a down-counter, then go to IDLE.
- out_0/out_1 = 0 whenever out_valid=0.
- in_ready=0 and rnd_ready=0 outside their states. Input held valid across non-IDLE states is not consumed.
- Each RNG word is consumed exactly once and never reused across operations.
- Latency: accept at cycle T, rnd_valid present at T+1 → EXEC at T+2, out_valid at T+3.
- Minimum period per operation: 4+FLUSH_CYCLES cycles.
- Simultaneous in_valid and rnd_valid in IDLE: only the operand is taken; rnd is not consumed.
- Unmasked values are never formed: the sequencer never XORs shares together.

Decomposition:
- Package masked_xor_seq_pkg holds: state enum type (3-bit encoding), default FLUSH_CYCLES, flush counter width constant (4).
- No sub-module: the core stays external through the core_* ports. The FSM, share registers and counters live in one module.

Test Plan:
1. Basic op: a0=1,a1=0,b0=1,b1=1, rnd=3'b101, out_ready=1 → core_* nonzero only in EXEC; out_valid at T+3 with out_0^out_1=1; op_count=1; FLUSH then in_ready=1 at T+5.
2. RNG stall: rnd_valid held low 10 cycles after accept → stays in WAIT_RND with core_*=0 and out_valid=0; result appears 2 cycles after rnd_valid rises.
3. Output backpressure: out_ready low 5 cycles → out_valid, out_0, out_1 stable; in_ready=0; op_count unchanged until the handshake.
4. Exhaustive: all 16 share combinations × 8 rnd values → reconstructed output equals (a0^a1)^(b0^b1); rnd consumed once per op (count rnd handshakes = ops).
5. Reset mid-op: assert rst during EXEC and during DONE → next cycle IDLE, out_valid=0, all core_*/out=0, op_count=0.
6. Wrap and precharge: CNT_W=2, FLUSH_CYCLES=3, 5 back-to-back ops → op_count sequence 1,2,3,0,1; 3 zeroed FLUSH cycles between each op.
